// File: rtl/tdm_pkg.sv
// Shared types and constants for the two-channel TDM pair receiver.
// seg_encode maps a channel value onto the board's 7-segment image.
package tdm_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GOT_A = 1'b1
   } state_t;

   localparam logic [7:0] APAGADO = 8'b0000_0000;
   localparam logic [7:0] NUM_0   = 8'b0011_1111;
   localparam logic [7:0] NUM_1   = 8'b0000_0110;
   localparam logic [7:0] NUM_2   = 8'b0101_1011;
   localparam logic [7:0] NUM_3   = 8'b0100_1111;

   localparam logic SEL_A = 1'b0;
   localparam logic SEL_B = 1'b1;

   function automatic logic [7:0] seg_encode(input logic [31:0] value);
      case (value)
         32'd0:   return NUM_0;
         32'd1:   return NUM_1;
         32'd2:   return NUM_2;
         32'd3:   return NUM_3;
         default: return APAGADO;
      endcase
   endfunction

endpackage

// File: rtl/strobe_debouncer.sv
// Two-flop synchronizer and debouncer for the strobe switch.
// Emits a single-cycle pulse on each rising edge of the debounced level.
module strobe_debouncer #(
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic strobe_i,
   output logic rise_o
);

   logic       sync1_q, sync2_q;
   logic       level_q, level_d;
   logic       level_prev_q;
   logic [7:0] cnt_q, cnt_d;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         sync1_q      <= 1'b0;
         sync2_q      <= 1'b0;
         level_q      <= 1'b0;
         level_prev_q <= 1'b0;
         cnt_q        <= '0;
      end else begin
         sync1_q      <= strobe_i;
         sync2_q      <= sync1_q;
         level_q      <= level_d;
         level_prev_q <= level_q;
         cnt_q        <= cnt_d;
      end
   end

   // NOTE: every combinational output gets a default first, so no path can infer a latch.
   always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      // The count must sit at DEBOUNCE_CYCLES for one cycle before the level flips.
      if (sync2_q != level_q) begin
         if (cnt_q == 8'(DEBOUNCE_CYCLES)) begin
            level_d = ~level_q;
         end else begin
            cnt_d = cnt_q + 8'd1;
         end
      end
   end

   assign rise_o = level_q & ~level_prev_q;

endmodule

// File: rtl/tdm_pair_receiver.sv
// Receiver for the A/B time-multiplexed link: pairs A then B into a frame.
// Define TDM_SEG_DISPLAY_EN to build the registered 7-segment image of info_a.
module tdm_pair_receiver
   import tdm_pkg::*;
#(
   parameter int unsigned NBITS_DATA      = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned NBITS_CNT       = 8
) (
   input  logic                  clk_2,
   input  logic                  reset_n,
   input  logic [NBITS_DATA-1:0] data_in,
   input  logic                  sel_in,
   input  logic                  strobe_in,
   output logic [NBITS_DATA-1:0] info_a,
   output logic [NBITS_DATA-1:0] info_b,
   output logic                  frame_valid,
   output logic                  frame_error,
   output logic                  busy,
   output logic [NBITS_CNT-1:0]  frame_count,
   output logic [NBITS_CNT-1:0]  err_count,
   output logic [7:0]            seg
);

   logic [NBITS_DATA-1:0] data_s1_q, data_s2_q;
   logic                  sel_s1_q, sel_s2_q;
   logic                  event_w;

   state_t                state_q, state_d;
   logic [NBITS_DATA-1:0] hold_a_q, hold_a_d;
   logic [NBITS_DATA-1:0] info_a_q, info_a_d;
   logic [NBITS_DATA-1:0] info_b_q, info_b_d;
   logic                  valid_q, valid_d;
   logic                  error_q, error_d;
   logic [NBITS_CNT-1:0]  frame_cnt_q, frame_cnt_d;
   logic [NBITS_CNT-1:0]  err_cnt_q, err_cnt_d;

   strobe_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_strobe_debouncer (
      .clk_i    (clk_2),
      .rst_n_i  (reset_n),
      .strobe_i (strobe_in),
      .rise_o   (event_w)
   );

   always_ff @(posedge clk_2) begin
      if (!reset_n) begin
         data_s1_q   <= '0;
         data_s2_q   <= '0;
         sel_s1_q    <= 1'b0;
         sel_s2_q    <= 1'b0;
         state_q     <= IDLE;
         hold_a_q    <= '0;
         info_a_q    <= '0;
         info_b_q    <= '0;
         valid_q     <= 1'b0;
         error_q     <= 1'b0;
         frame_cnt_q <= '0;
         err_cnt_q   <= '0;
      end else begin
         data_s1_q   <= data_in;
         data_s2_q   <= data_s1_q;
         sel_s1_q    <= sel_in;
         sel_s2_q    <= sel_s1_q;
         state_q     <= state_d;
         hold_a_q    <= hold_a_d;
         info_a_q    <= info_a_d;
         info_b_q    <= info_b_d;
         valid_q     <= valid_d;
         error_q     <= error_d;
         frame_cnt_q <= frame_cnt_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      hold_a_d    = hold_a_q;
      info_a_d    = info_a_q;
      info_b_d    = info_b_q;
      valid_d     = 1'b0;
      error_d     = 1'b0;
      frame_cnt_d = frame_cnt_q;
      err_cnt_d   = err_cnt_q;
      if (event_w) begin
         case (state_q)
            IDLE: begin
               if (sel_s2_q == SEL_A) begin
                  hold_a_d = data_s2_q;
                  state_d  = GOT_A;
               end else begin
                  error_d = 1'b1;
               end
            end
            GOT_A: begin
               if (sel_s2_q == SEL_B) begin
                  info_a_d    = hold_a_q;
                  info_b_d    = data_s2_q;
                  valid_d     = 1'b1;
                  frame_cnt_d = frame_cnt_q + NBITS_CNT'(1);
                  state_d     = IDLE;
               end else begin
                  // A newer A replaces the held one; the overwrite is still a violation.
                  hold_a_d = data_s2_q;
                  error_d  = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
      if (error_d && (err_cnt_q != '1)) begin
         err_cnt_d = err_cnt_q + NBITS_CNT'(1);
      end
   end

`ifdef TDM_SEG_DISPLAY_EN
   logic [7:0] seg_q, seg_d;

   // Kept separate from info_a so the display stays blank until the first frame.
   always_comb begin
      seg_d = seg_q;
      if (valid_d) begin
         seg_d = seg_encode(32'(info_a_d));
      end
   end

   always_ff @(posedge clk_2) begin
      if (!reset_n) begin
         seg_q <= APAGADO;
      end else begin
         seg_q <= seg_d;
      end
   end

   assign seg = seg_q;
`else
   assign seg = APAGADO;
`endif

   assign info_a      = info_a_q;
   assign info_b      = info_b_q;
   assign frame_valid = valid_q;
   assign frame_error = error_q;
   assign busy        = (state_q == GOT_A);
   assign frame_count = frame_cnt_q;
   assign err_count   = err_cnt_q;

endmodule

// File: tb/tb_tdm_pair_receiver.sv
// Directed self-checking bench for tdm_pair_receiver with DEBOUNCE_CYCLES=4.
// Inputs are driven 1 time unit after each rising edge; outputs are sampled there too.
module tb_tdm_pair_receiver;

   logic       clk_2 = 1'b0;
   logic       reset_n;
   logic [1:0] data_in;
   logic       sel_in;
   logic       strobe_in;
   logic [1:0] info_a, info_b;
   logic       frame_valid, frame_error, busy;
   logic [7:0] frame_count, err_count, seg;

   int n_checks = 0;
   int n_fail   = 0;

   tdm_pair_receiver #(
      .NBITS_DATA(2),
      .DEBOUNCE_CYCLES(4),
      .NBITS_CNT(8)
   ) dut (
      .clk_2       (clk_2),
      .reset_n     (reset_n),
      .data_in     (data_in),
      .sel_in      (sel_in),
      .strobe_in   (strobe_in),
      .info_a      (info_a),
      .info_b      (info_b),
      .frame_valid (frame_valid),
      .frame_error (frame_error),
      .busy        (busy),
      .frame_count (frame_count),
      .err_count   (err_count),
      .seg         (seg)
   );

   always #5 clk_2 = ~clk_2;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] seg_of(input logic [1:0] v);
`ifdef TDM_SEG_DISPLAY_EN
      case (v)
         2'd0:    return 8'b0011_1111;
         2'd1:    return 8'b0000_0110;
         2'd2:    return 8'b0101_1011;
         default: return 8'b0100_1111;
      endcase
`else
      return 8'h00 & {8{v[0]}};
`endif
   endfunction

   // Strobe goes high just before edge i=0, stays high for `hi` edges, then low for 10.
   task automatic send(input logic [1:0] d, input logic s, input int hi,
                       output int fv_n, output int fe_n, output int first_idx,
                       output logic busy6, output logic busy7);
      data_in   = d;
      sel_in    = s;
      strobe_in = 1'b1;
      fv_n      = 0;
      fe_n      = 0;
      first_idx = -1;
      busy6     = 1'b0;
      busy7     = 1'b0;
      for (int i = 0; i < hi + 10; i++) begin
         @(posedge clk_2);
         #1;
         if (frame_valid) fv_n++;
         if (frame_error) fe_n++;
         if ((frame_valid || frame_error) && first_idx < 0) first_idx = i;
         if (i == 6) busy6 = busy;
         if (i == 7) busy7 = busy;
         if (i == hi - 1) strobe_in = 1'b0;
      end
   endtask

   int   fv_n, fe_n, idx, pulses;
   logic b6, b7;

   initial begin
      reset_n   = 1'b0;
      data_in   = 2'd0;
      sel_in    = 1'b0;
      strobe_in = 1'b0;
      repeat (3) @(posedge clk_2);
      #1;
      reset_n = 1'b1;

      // Reset state and quiet idle period.
      pulses = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk_2);
         #1;
         if (frame_valid || frame_error) pulses++;
      end
      check("idle_pulses", pulses, 0);
      check("rst_info_a", info_a, 0);
      check("rst_info_b", info_b, 0);
      check("rst_busy", busy, 0);
      check("rst_frame_count", frame_count, 0);
      check("rst_err_count", err_count, 0);
      check("rst_seg", seg, 0);

      // A=2 then B=1: latency and frame contents.
      send(2'd2, 1'b0, 10, fv_n, fe_n, idx, b6, b7);
      check("a_busy_k6", b6, 0);
      check("a_busy_k7", b7, 1);
      check("a_no_pulse", fv_n + fe_n, 0);
      send(2'd1, 1'b1, 10, fv_n, fe_n, idx, b6, b7);
      check("b_valid_count", fv_n, 1);
      check("b_valid_edge", idx, 7);
      check("b_no_error", fe_n, 0);
      check("f1_info_a", info_a, 2);
      check("f1_info_b", info_b, 1);
      check("f1_frame_count", frame_count, 1);
      check("f1_busy", busy, 0);
      check("f1_seg", seg, seg_of(2'd2));

      // B without A in IDLE.
      send(2'd3, 1'b1, 10, fv_n, fe_n, idx, b6, b7);
      check("bidle_error", fe_n, 1);
      check("bidle_error_edge", idx, 7);
      check("bidle_no_valid", fv_n, 0);
      check("bidle_err_count", err_count, 1);
      check("bidle_info_a", info_a, 2);
      check("bidle_info_b", info_b, 1);

      // A=3, A=0 (newest wins, one error), B=2.
      send(2'd3, 1'b0, 10, fv_n, fe_n, idx, b6, b7);
      check("a3_no_error", fe_n, 0);
      send(2'd0, 1'b0, 10, fv_n, fe_n, idx, b6, b7);
      check("aa_error", fe_n, 1);
      check("aa_busy", busy, 1);
      check("aa_err_count", err_count, 2);
      send(2'd2, 1'b1, 10, fv_n, fe_n, idx, b6, b7);
      check("f2_valid", fv_n, 1);
      check("f2_info_a", info_a, 0);
      check("f2_info_b", info_b, 2);
      check("f2_frame_count", frame_count, 2);
      check("f2_seg", seg, seg_of(2'd0));

      // Glitch shorter than the debounce window.
      send(2'd1, 1'b0, 3, fv_n, fe_n, idx, b6, b7);
      check("glitch_pulses", fv_n + fe_n, 0);
      check("glitch_busy", busy, 0);

      // Reset while holding A discards it.
      send(2'd2, 1'b0, 10, fv_n, fe_n, idx, b6, b7);
      check("pre_rst_busy", busy, 1);
      reset_n = 1'b0;
      @(posedge clk_2);
      #1;
      reset_n = 1'b1;
      check("mid_rst_busy", busy, 0);
      check("mid_rst_frame_count", frame_count, 0);
      check("mid_rst_info_a", info_a, 0);
      send(2'd1, 1'b1, 10, fv_n, fe_n, idx, b6, b7);
      check("post_rst_error", fe_n, 1);
      check("post_rst_no_valid", fv_n, 0);
      check("post_rst_err_count", err_count, 1);
      check("post_rst_seg", seg, 0);

      // frame_count wrap.
      for (int i = 0; i < 255; i++) begin
         send(2'(i), 1'b0, 10, fv_n, fe_n, idx, b6, b7);
         send(2'(i + 1), 1'b1, 10, fv_n, fe_n, idx, b6, b7);
      end
      check("fc_255", frame_count, 255);
      send(2'd3, 1'b0, 10, fv_n, fe_n, idx, b6, b7);
      send(2'd0, 1'b1, 10, fv_n, fe_n, idx, b6, b7);
      check("fc_wrap", frame_count, 0);
      check("wrap_info_a", info_a, 3);
      check("wrap_info_b", info_b, 0);
      check("wrap_seg", seg, seg_of(2'd3));

      // err_count saturation: 1 error already, 300 more.
      for (int i = 0; i < 253; i++) begin
         send(2'd0, 1'b1, 10, fv_n, fe_n, idx, b6, b7);
      end
      check("ec_254", err_count, 254);
      for (int i = 0; i < 47; i++) begin
         send(2'd0, 1'b1, 10, fv_n, fe_n, idx, b6, b7);
      end
      check("ec_sat", err_count, 255);
      check("ec_sat_pulse", fe_n, 1);
      check("ec_frame_count", frame_count, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
